// File: rtl/cpu_pkg.sv
// cpu_pkg: shared forwarding select codes, stage-tag struct and tag-match helper
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_AWB = 2'b11;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_tag_t;
  function automatic logic tag_writes(input stage_tag_t t, input logic [REG_ADDR_W-1:0] r);
    return t.valid & t.regwrite & (t.rd == r) & (r != '0);
  endfunction
endpackage

// File: rtl/fwd_sel_prio.sv
// fwd_sel_prio: per-operand forwarding priority encoder, newest producer wins
// Ports: i_rs/i_used source operand; i_ex/i_mem/i_wb pre-edge stage tags; o_sel mux select.
module fwd_sel_prio
  import cpu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_used,
  input  stage_tag_t            i_ex,
  input  stage_tag_t            i_mem,
  input  stage_tag_t            i_wb,
  output logic [1:0]            o_sel
);
  // Stage names shift by one at the edge: EX producer is in MEM next cycle, and so on.
  always_comb
    o_sel = !i_used                ? FWD_RF  :
            tag_writes(i_ex,  i_rs) ? FWD_MEM :
            tag_writes(i_mem, i_rs) ? FWD_WB  :
            tag_writes(i_wb,  i_rs) ? FWD_AWB : FWD_RF;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects, load-use stall and stall counter
// Ports: i_clk/i_rst clock and sync reset; i_id_* decoded ID instruction; i_flush kills ID;
// i_hold freezes everything; o_fwd_a_sel/o_fwd_b_sel registered mux selects for the
// instruction in EX; o_stall combinational load-use stall; o_stall_cnt saturating stall count.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_regwrite,
  input  logic                  i_id_memread,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_stall,
  output logic [CNT_W-1:0]      o_stall_cnt
);
  import cpu_pkg::*;
  stage_tag_t       r_ex, r_mem, r_wb, r_awb;
  stage_tag_t       w_id_tag;
  logic [1:0]       w_sel_a, w_sel_b;
  logic [1:0]       r_sel_a, r_sel_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_issue;
  always_comb begin
    w_id_tag = '{valid: 1'b1, rd: i_id_rd, regwrite: i_id_regwrite, memread: i_id_memread};
    o_stall  = i_id_valid & !i_flush & r_ex.valid & r_ex.memread & (r_ex.rd != '0) &
               ((i_id_rs1_used & (r_ex.rd == i_id_rs1)) | (i_id_rs2_used & (r_ex.rd == i_id_rs2)));
    w_issue  = i_id_valid & !i_flush & !o_stall;
  end
  fwd_sel_prio u_sel_a (
    .i_rs   (i_id_rs1),
    .i_used (i_id_rs1_used),
    .i_ex   (r_ex),
    .i_mem  (r_mem),
    .i_wb   (r_wb),
    .o_sel  (w_sel_a)
  );
  fwd_sel_prio u_sel_b (
    .i_rs   (i_id_rs2),
    .i_used (i_id_rs2_used),
    .i_ex   (r_ex),
    .i_mem  (r_mem),
    .i_wb   (r_wb),
    .o_sel  (w_sel_b)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_awb       <= '0;
      r_sel_a     <= FWD_RF;
      r_sel_b     <= FWD_RF;
      r_stall_cnt <= '0;
    end else if (!i_hold) begin
      r_awb   <= r_wb;
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_issue ? w_id_tag : '0;
      r_sel_a <= w_issue ? w_sel_a : FWD_RF;
      r_sel_b <= w_issue ? w_sel_b : FWD_RF;
      if (o_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  assign o_fwd_a_sel = r_sel_a;
  assign o_fwd_b_sel = r_sel_b;
  assign o_stall_cnt = r_stall_cnt;
endmodule
